// File: rtl/wt_dcache_ship_pred_if.sv
// Miss-unit <-> predictor bundle: lookup handshake, prediction, fill and hit events.
// The miss unit drives as master; the predictor consumes as slave.
interface wt_dcache_ship_pred_if #(
    parameter int NUM_SETS = 256,
    parameter int NUM_WAYS = 4,
    parameter int PC_W     = 64
);
    localparam int IDX_W = $clog2(NUM_SETS);
    localparam int WAY_W = $clog2(NUM_WAYS);

    logic             lookup_valid_i;
    logic             lookup_ready_o;
    logic [PC_W-1:0]  lookup_pc_i;
    logic             pred_valid_o;
    logic [1:0]       pred_o;
    logic             fill_i;
    logic [IDX_W-1:0] fill_idx_i;
    logic [WAY_W-1:0] fill_way_i;
    logic             hit_i;
    logic [IDX_W-1:0] hit_idx_i;
    logic [WAY_W-1:0] hit_way_i;

    modport master (
        output lookup_valid_i, lookup_pc_i, fill_i, fill_idx_i, fill_way_i,
               hit_i, hit_idx_i, hit_way_i,
        input  lookup_ready_o, pred_valid_o, pred_o
    );

    modport slave (
        input  lookup_valid_i, lookup_pc_i, fill_i, fill_idx_i, fill_way_i,
               hit_i, hit_idx_i, hit_way_i,
        output lookup_ready_o, pred_valid_o, pred_o
    );
endinterface

// File: rtl/wt_dcache_ship_pred.sv
// Signature-based re-reference predictor: PC signature -> SHCT 2-bit counter -> SRRIP insertion hint.
// Latency 1 cycle lookup->pred; one prediction outstanding, lookup_ready_o low until fill or flush.
module wt_dcache_ship_pred #(
    parameter int NUM_SETS = 256,
    parameter int NUM_WAYS = 4,
    parameter int SIG_W    = 8,
    parameter int PC_W     = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   flush_i,
    wt_dcache_ship_pred_if.slave   bus
);
    localparam int SHCT_N = 1 << SIG_W;

    logic [1:0]          shct_q [SHCT_N];
    logic [1:0]          shct_d [SHCT_N];
    logic [NUM_WAYS-1:0] line_vld_q   [NUM_SETS];
    logic [NUM_WAYS-1:0] line_vld_d   [NUM_SETS];
    logic [NUM_WAYS-1:0] line_reuse_q [NUM_SETS];
    logic [NUM_WAYS-1:0] line_reuse_d [NUM_SETS];
    logic [SIG_W-1:0]    line_sig_q   [NUM_SETS][NUM_WAYS];
    logic [SIG_W-1:0]    line_sig_d   [NUM_SETS][NUM_WAYS];

    logic             pend_v_q, pend_v_d;
    logic [SIG_W-1:0] pend_sig_q, pend_sig_d;
    logic [1:0]       pend_pred_q, pend_pred_d;

    logic [SIG_W-1:0] lookup_sig;
    logic [1:0]       lookup_pred;
    logic             lookup_acc;
    logic             fill_evt, hit_evt;
    logic             dead_evt, train_evt;
    logic [SIG_W-1:0] dec_sig, inc_sig;
    logic             unused_pc;

    // Only the signature bits of the PC participate in the hash.
    assign unused_pc = ^{bus.lookup_pc_i[PC_W-1:2*SIG_W+2], bus.lookup_pc_i[1:0]};

    always_comb begin
        lookup_sig = bus.lookup_pc_i[SIG_W+1:2] ^ bus.lookup_pc_i[2*SIG_W+1:SIG_W+2];
        lookup_acc = bus.lookup_valid_i && !pend_v_q && !flush_i;
        fill_evt   = bus.fill_i && !flush_i;
        // A fill to the same line overrides the hit: the old contents are gone.
        hit_evt    = bus.hit_i && !flush_i &&
                     !(fill_evt && bus.hit_idx_i == bus.fill_idx_i && bus.hit_way_i == bus.fill_way_i);
        dead_evt   = fill_evt && line_vld_q[bus.fill_idx_i][bus.fill_way_i] &&
                     !line_reuse_q[bus.fill_idx_i][bus.fill_way_i];
        train_evt  = hit_evt && line_vld_q[bus.hit_idx_i][bus.hit_way_i] &&
                     !line_reuse_q[bus.hit_idx_i][bus.hit_way_i];
        dec_sig    = line_sig_q[bus.fill_idx_i][bus.fill_way_i];
        inc_sig    = line_sig_q[bus.hit_idx_i][bus.hit_way_i];
    end

    always_comb begin
        case (shct_q[lookup_sig])
            2'd0:    lookup_pred = 2'd0;
            2'd3:    lookup_pred = 2'd3;
            default: lookup_pred = 2'd1;
        endcase
    end

    always_comb begin
        shct_d       = shct_q;
        line_vld_d   = line_vld_q;
        line_reuse_d = line_reuse_q;
        line_sig_d   = line_sig_q;
        pend_v_d     = pend_v_q;
        pend_sig_d   = pend_sig_q;
        pend_pred_d  = pend_pred_q;

        // Opposing updates to one counter cancel.
        if (train_evt && !(dead_evt && dec_sig == inc_sig) && shct_q[inc_sig] != 2'd3) begin
            shct_d[inc_sig] = shct_q[inc_sig] + 2'd1;
        end
        if (dead_evt && !(train_evt && dec_sig == inc_sig) && shct_q[dec_sig] != 2'd0) begin
            shct_d[dec_sig] = shct_q[dec_sig] - 2'd1;
        end

        if (flush_i) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                line_vld_d[s]   = '0;
                line_reuse_d[s] = '0;
            end
            pend_v_d = 1'b0;
        end else begin
            if (train_evt) begin
                line_reuse_d[bus.hit_idx_i][bus.hit_way_i] = 1'b1;
            end
            if (fill_evt) begin
                line_vld_d[bus.fill_idx_i][bus.fill_way_i]   = pend_v_q;
                line_reuse_d[bus.fill_idx_i][bus.fill_way_i] = 1'b0;
                if (pend_v_q) begin
                    line_sig_d[bus.fill_idx_i][bus.fill_way_i] = pend_sig_q;
                end
                pend_v_d = 1'b0;
            end
            if (lookup_acc) begin
                pend_v_d    = 1'b1;
                pend_sig_d  = lookup_sig;
                pend_pred_d = lookup_pred;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < SHCT_N; i++) begin
                shct_q[i] <= 2'd1;
            end
            for (int s = 0; s < NUM_SETS; s++) begin
                line_vld_q[s]   <= '0;
                line_reuse_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    line_sig_q[s][w] <= '0;
                end
            end
            pend_v_q    <= 1'b0;
            pend_sig_q  <= '0;
            pend_pred_q <= 2'd0;
        end else begin
            shct_q       <= shct_d;
            line_vld_q   <= line_vld_d;
            line_reuse_q <= line_reuse_d;
            line_sig_q   <= line_sig_d;
            pend_v_q     <= pend_v_d;
            pend_sig_q   <= pend_sig_d;
            pend_pred_q  <= pend_pred_d;
        end
    end

    assign bus.lookup_ready_o = !pend_v_q;
    assign bus.pred_valid_o   = pend_v_q;
    assign bus.pred_o         = pend_pred_q;
endmodule

// File: tb/tb_wt_dcache_ship_pred.sv
// Bench for wt_dcache_ship_pred: scenario tasks plus a prediction scoreboard.
module tb_wt_dcache_ship_pred;
    localparam int NUM_SETS = 256;
    localparam int NUM_WAYS = 4;
    localparam int SIG_W    = 8;
    localparam int PC_W     = 64;
    localparam logic [PC_W-1:0] PC_A = 64'h1000;   // signature 0x04
    localparam logic [PC_W-1:0] PC_B = 64'h2000;   // signature 0x08

    logic clk = 1'b0;
    logic rst;
    logic flush;
    int   total = 0;
    int   bad   = 0;
    logic [1:0] sb [$];
    logic [1:0] exp_p;
    logic       pv_prev = 1'b0;

    always #5 clk = ~clk;

    wt_dcache_ship_pred_if #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .PC_W(PC_W)) bus ();

    wt_dcache_ship_pred #(.NUM_SETS(NUM_SETS), .NUM_WAYS(NUM_WAYS), .SIG_W(SIG_W), .PC_W(PC_W)) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .flush_i (flush),
        .bus     (bus)
    );

    // Scoreboard: each new prediction is checked against the value queued at lookup time.
    always @(negedge clk) begin
        if (bus.pred_valid_o === 1'b1 && pv_prev !== 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected: pred_o=%0d appeared with no lookup queued", bus.pred_o);
            end else begin
                exp_p = sb.pop_front();
                if (bus.pred_o !== exp_p) begin
                    bad++;
                    $display("FAIL sb_pred: pred_o=%0d expected %0d at t=%0t", bus.pred_o, exp_p, $time);
                end
            end
        end
        pv_prev = bus.pred_valid_o;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush              = 1'b0;
        bus.lookup_valid_i = 1'b0;
        bus.lookup_pc_i    = '0;
        bus.fill_i         = 1'b0;
        bus.fill_idx_i     = '0;
        bus.fill_way_i     = '0;
        bus.hit_i          = 1'b0;
        bus.hit_idx_i      = '0;
        bus.hit_way_i      = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic lookup_req(input logic [PC_W-1:0] pc, input logic [1:0] exp);
        bus.lookup_valid_i = 1'b1;
        bus.lookup_pc_i    = pc;
        sb.push_back(exp);
        tick();
        bus.lookup_valid_i = 1'b0;
    endtask

    task automatic fill_line(input int idx, input int way);
        bus.fill_i     = 1'b1;
        bus.fill_idx_i = idx[7:0];
        bus.fill_way_i = way[1:0];
        tick();
        bus.fill_i = 1'b0;
    endtask

    task automatic hit_line(input int idx, input int way);
        bus.hit_i     = 1'b1;
        bus.hit_idx_i = idx[7:0];
        bus.hit_way_i = way[1:0];
        tick();
        bus.hit_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (bus.lookup_ready_o !== 1'b1) begin
            bad++; $display("FAIL reset_ready: got %b expected 1", bus.lookup_ready_o);
        end
        total++;
        if (bus.pred_valid_o !== 1'b0) begin
            bad++; $display("FAIL reset_pred_valid: got %b expected 0", bus.pred_valid_o);
        end
        total++;
        if (bus.pred_o !== 2'd0) begin
            bad++; $display("FAIL reset_pred: got %0d expected 0", bus.pred_o);
        end
    endtask

    task automatic test_lookup();
        lookup_req(PC_A, 2'd1);
        total++;
        if (bus.pred_valid_o !== 1'b1 || bus.lookup_ready_o !== 1'b0) begin
            bad++; $display("FAIL lookup_latency: valid=%b ready=%b expected 1/0", bus.pred_valid_o, bus.lookup_ready_o);
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus.lookup_valid_i = 1'b1;   // must be ignored while pending
                bus.lookup_pc_i    = PC_B;
            end
            tick();
            bus.lookup_valid_i = 1'b0;
            total++;
            if (bus.pred_valid_o !== 1'b1 || bus.pred_o !== 2'd1) begin
                bad++; $display("FAIL lookup_hold: cycle %0d valid=%b pred=%0d expected 1/1", i, bus.pred_valid_o, bus.pred_o);
            end
        end
        bus.fill_i = 1'b1; bus.fill_idx_i = 8'd5; bus.fill_way_i = 2'd2;
        #1;
        total++;
        if (bus.pred_valid_o !== 1'b1 || bus.pred_o !== 2'd1) begin
            bad++; $display("FAIL fill_cycle_pred: valid=%b pred=%0d expected 1/1", bus.pred_valid_o, bus.pred_o);
        end
        tick();
        bus.fill_i = 1'b0;
        total++;
        if (bus.lookup_ready_o !== 1'b1 || bus.pred_valid_o !== 1'b0) begin
            bad++; $display("FAIL fill_release: ready=%b valid=%b expected 1/0", bus.lookup_ready_o, bus.pred_valid_o);
        end
    endtask

    // Line (5,2) holds sig 0x04, counter 1.
    task automatic test_reuse();
        hit_line(5, 2);
        hit_line(5, 2);                  // counter 2, second hit must not train
        lookup_req(PC_A, 2'd1);
        fill_line(6, 0);
        hit_line(6, 0);                  // counter 3
        lookup_req(PC_A, 2'd3);
        fill_line(6, 1);
        lookup_req(PC_B, 2'd1);          // untouched signature still at reset value
        fill_line(6, 2);
    endtask

    task automatic test_dead_eviction();
        do_reset();
        lookup_req(PC_A, 2'd1);
        fill_line(7, 0);
        lookup_req(PC_A, 2'd1);
        fill_line(7, 0);                 // dead eviction: counter 0
        lookup_req(PC_A, 2'd0);
        fill_line(8, 0);
    endtask

    task automatic test_simultaneous();
        do_reset();
        lookup_req(PC_A, 2'd1);
        fill_line(1, 0);
        lookup_req(PC_A, 2'd1);
        fill_line(2, 1);
        lookup_req(PC_A, 2'd1);
        bus.hit_i = 1'b1; bus.hit_idx_i = 8'd1; bus.hit_way_i = 2'd0;
        fill_line(2, 1);                 // +1 and -1 on 0x04 cancel
        bus.hit_i = 1'b0;
        lookup_req(PC_A, 2'd1);          // catches a lone decrement (would be 0)
        fill_line(10, 0);
        hit_line(2, 1);                  // counter 1 -> 2
        lookup_req(PC_A, 2'd1);          // catches a lone increment (would be 3)
        fill_line(10, 1);
    endtask

    // Counter is 2 on entry.
    task automatic test_flush();
        lookup_req(PC_A, 2'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        total++;
        if (bus.pred_valid_o !== 1'b0 || bus.lookup_ready_o !== 1'b1) begin
            bad++; $display("FAIL flush_pending: valid=%b ready=%b expected 0/1", bus.pred_valid_o, bus.lookup_ready_o);
        end
        hit_line(2, 1);                  // flushed line: no training
        fill_line(3, 3);                 // no pending: untracked
        fill_line(3, 3);                 // evicting an untracked line: no decrement
        lookup_req(PC_A, 2'd1);
        fill_line(11, 0);
        hit_line(11, 0);                 // 2 -> 3 only if flush kept the counter
        lookup_req(PC_A, 2'd3);
        fill_line(11, 1);
    endtask

    // Counter is 3 on entry; (11,1) holds sig 0x04 unreused.
    task automatic test_saturation();
        for (int w = 0; w < 4; w++) begin
            lookup_req(PC_A, 2'd3);
            fill_line(12, w);
        end
        for (int w = 0; w < 4; w++) hit_line(12, w);
        lookup_req(PC_A, 2'd3);
        fill_line(13, 0);
        lookup_req(PC_A, 2'd3);
        fill_line(13, 0);                // 3 -> 2
        lookup_req(PC_A, 2'd1);
        fill_line(11, 1);                // 2 -> 1
        lookup_req(PC_A, 2'd1);
        fill_line(13, 0);                // 1 -> 0
        lookup_req(PC_A, 2'd0);
        fill_line(11, 1);                // stays 0
        lookup_req(PC_A, 2'd0);
        fill_line(13, 0);                // stays 0
        lookup_req(PC_A, 2'd0);
        fill_line(14, 0);
        hit_line(11, 1);                 // 0 -> 1
        lookup_req(PC_A, 2'd1);
        bus.hit_i = 1'b1; bus.hit_idx_i = 8'd14; bus.hit_way_i = 2'd0;
        fill_line(14, 0);                // only the eviction applies: 1 -> 0
        bus.hit_i = 1'b0;
        lookup_req(PC_A, 2'd0);
        fill_line(15, 0);
        hit_line(14, 0);                 // refilled line still eligible: 0 -> 1
        lookup_req(PC_A, 2'd1);
        fill_line(15, 1);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_lookup();
        test_reuse();
        test_dead_eviction();
        test_simultaneous();
        test_flush();
        test_saturation();
        tick();
        tick();
        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_drain: %0d predictions never appeared, expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
